// File: rtl/led_display_pkg.sv
// Shared types for the LED panel pixel path: RGB888 words, pixel pairs,
// read-return tags and the frame reader FSM states.
package led_display_pkg;

  localparam int ROW_W   = 15;
  localparam int PLANE_W = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [2:0]         top;
    logic [2:0]         bot;
    logic [ROW_W-1:0]   row;
    logic [PLANE_W-1:0] plane;
    logic               last;
  } pix_pair_t;

  typedef struct packed {
    logic               valid;
    logic               is_bot;
    logic [ROW_W-1:0]   row;
    logic [PLANE_W-1:0] plane;
    logic               last;
  } rd_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_TOP,
    RD_BOT,
    DRAIN
  } rd_state_e;

  function automatic logic [2:0] plane_bits(
    rgb888_t    px,
    logic [2:0] bit_idx
  );
    return {px.r[bit_idx], px.g[bit_idx], px.b[bit_idx]};
  endfunction

endpackage

// File: rtl/led_frame_reader_if.sv
// Pixel-pair valid/ready stream from the frame reader to the display driver.
// master: pair source (valid, top, bot, row, plane, last); slave: sink (ready).
interface led_frame_reader_if #(
  parameter int ROW_W   = 4,
  parameter int PLANE_W = 3
);

  logic               pix_valid;
  logic               pix_ready;
  logic [2:0]         pix_top;
  logic [2:0]         pix_bot;
  logic [ROW_W-1:0]   pix_row;
  logic [PLANE_W-1:0] pix_plane;
  logic               pix_last;

  modport master (
    output pix_valid, pix_top, pix_bot,
    output pix_row, pix_plane, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_top, pix_bot,
    input  pix_row, pix_plane, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/pixel_pair_fifo.sv
// Two-entry synchronous FIFO of pix_pair_t. Ports: push/din, pop/dout,
// full/empty. dout reads as zero while empty.
module pixel_pair_fifo
  import led_display_pkg::*;
(
  input  logic      clk_in,
  input  logic      n_reset_in,
  input  logic      push,
  input  pix_pair_t din,
  input  logic      pop,
  output pix_pair_t dout,
  output logic      full,
  output logic      empty
);

  pix_pair_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_in or posedge n_reset_in) begin
    if (n_reset_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop)
        rd_ptr <= !rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/led_frame_reader.sv
// Walks frame RAM in panel scan order and streams one bit plane of each
// top/bottom pixel pair. Ports: clk_in, n_reset_in (async, active high),
// enable_in, RAM read port (ram_en/addr/data), pix stream, frame_done_out.
module led_frame_reader
  import led_display_pkg::*;
#(
  parameter int NUM_ROWS    = 32,
  parameter int NUM_COLS    = 64,
  parameter int BIT_DEPTH   = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic               clk_in,
  input  logic               n_reset_in,
  input  logic               enable_in,
  output logic               ram_en_out,
  output logic [15:0]        ram_addr_out,
  input  logic [23:0]        ram_data_in,
  led_frame_reader_if.master pix,
  output logic               frame_done_out
);

  localparam int HALF = NUM_ROWS / 2;
  localparam int RW   = HALF > 1 ? $clog2(HALF) : 1;
  localparam int PW   = BIT_DEPTH > 1 ? $clog2(BIT_DEPTH) : 1;
  localparam int CW   = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  localparam int LAT  = RAM_LATENCY;

  localparam logic [RW-1:0] ROW_MAX   = RW'(HALF - 1);
  localparam logic [PW-1:0] PLANE_MAX = PW'(BIT_DEPTH - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(NUM_COLS - 1);

  if (NUM_ROWS * NUM_COLS > 65536 || NUM_ROWS % 2 != 0 ||
      LAT < 1 || LAT > 2 || BIT_DEPTH < 1 || BIT_DEPTH > 8)
  begin : g_bad_cfg
    $error("led_frame_reader: illegal parameter set");
  end

  rd_state_e   state_q, state_d;
  logic [RW-1:0] row_q;
  logic [PW-1:0] plane_q;
  logic [CW-1:0] col_q;
  logic [1:0]  inflight_q;
  logic [2:0]  top_q;
  rd_tag_t     tag_q [LAT];
  rd_tag_t     new_tag;
  rd_tag_t     ret;
  logic        top_issue, bot_issue;
  logic        frame_end, credit_ok;
  logic        pair_push;
  logic [1:0]  occ;
  logic [2:0]  bit_idx;
  logic [2:0]  ret_bits;
  logic [15:0] row_sel;
  pix_pair_t   push_pair;
  pix_pair_t   head;
  logic        fifo_full, fifo_empty;
  logic        unused_bits;

  assign frame_end = row_q == ROW_MAX &&
                     plane_q == PLANE_MAX &&
                     col_q == COL_MAX;

  // Pairs are only requested while the FIFO can absorb every outstanding one.
  assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign credit_ok = (3'(occ) + 3'(inflight_q)) < 3'd2;

  always_comb begin
    state_d        = state_q;
    ram_en_out     = 1'b0;
    top_issue      = 1'b0;
    bot_issue      = 1'b0;
    frame_done_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_in)
          state_d = RD_TOP;
      end
      RD_TOP: begin
        if (credit_ok) begin
          ram_en_out = 1'b1;
          top_issue  = 1'b1;
          state_d    = RD_BOT;
        end
      end
      RD_BOT: begin
        ram_en_out = 1'b1;
        bot_issue  = 1'b1;
        state_d    = frame_end ? DRAIN : RD_TOP;
      end
      DRAIN: begin
        if (fifo_empty && inflight_q == 2'd0) begin
          frame_done_out = 1'b1;
          state_d        = enable_in ? RD_TOP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_sel = 16'(row_q) +
                   (state_q == RD_BOT ? 16'(HALF) : 16'd0);
  assign ram_addr_out = 16'(row_sel * 16'(NUM_COLS)) + 16'(col_q);

  always_comb begin
    new_tag        = '0;
    new_tag.valid  = ram_en_out;
    new_tag.is_bot = bot_issue;
    new_tag.row    = ROW_W'(row_q);
    new_tag.plane  = PLANE_W'(plane_q);
    new_tag.last   = col_q == COL_MAX;
  end

  always_ff @(posedge clk_in or posedge n_reset_in) begin
    if (n_reset_in) begin
      for (int i = 0; i < LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i < LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret       = tag_q[LAT-1];
  assign bit_idx   = 3'(8 - BIT_DEPTH) + 3'(ret.plane);
  assign ret_bits  = plane_bits(rgb888_t'(ram_data_in), bit_idx);
  assign pair_push = ret.valid && ret.is_bot;

  always_comb begin
    push_pair       = '0;
    push_pair.top   = top_q;
    push_pair.bot   = ret_bits;
    push_pair.row   = ret.row;
    push_pair.plane = ret.plane;
    push_pair.last  = ret.last;
  end

  always_ff @(posedge clk_in or posedge n_reset_in) begin
    if (n_reset_in) begin
      state_q    <= IDLE;
      row_q      <= '0;
      plane_q    <= '0;
      col_q      <= '0;
      inflight_q <= 2'd0;
      top_q      <= 3'd0;
    end else begin
      state_q <= state_d;
      if (bot_issue) begin
        if (frame_end) begin
          row_q   <= '0;
          plane_q <= '0;
          col_q   <= '0;
        end else if (col_q == COL_MAX) begin
          col_q <= '0;
          if (plane_q == PLANE_MAX) begin
            plane_q <= '0;
            row_q   <= row_q + RW'(1);
          end else begin
            plane_q <= plane_q + PW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      inflight_q <= inflight_q + 2'(top_issue) - 2'(pair_push);
      if (ret.valid && !ret.is_bot)
        top_q <= ret_bits;
    end
  end

  pixel_pair_fifo u_fifo (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .push       (pair_push),
    .din        (push_pair),
    .pop        (pix.pix_valid && pix.pix_ready),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_top   = head.top;
  assign pix.pix_bot   = head.bot;
  assign pix.pix_row   = head.row[RW-1:0];
  assign pix.pix_plane = head.plane[PW-1:0];
  assign pix.pix_last  = head.last;
  assign unused_bits   = ^{head.row, head.plane};

endmodule

// File: tb/tb_led_frame_reader.sv
// Bench for led_frame_reader: two instances (RAM latency 1 and 2) read a
// shared frame image; a scan-order model predicts every address and pair.
module tb_led_frame_reader;

  localparam int NR = 32;
  localparam int NC = 64;
  localparam int BD = 8;
  localparam int NP = (NR / 2) * BD * NC;
  localparam int TMO = 45000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic rdy0 = 1'b1;
  logic rdy1 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [23:0] mem [0:2047];
  logic        ram_en   [2];
  logic [15:0] ram_addr [2];
  logic [23:0] ram_data [2];
  logic        done     [2];
  logic        vld      [2];
  logic [13:0] obs      [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Pair n in scan order: row outer, plane, column inner.
  function automatic logic [13:0] exp_pair(int n);
    int r, p, c;
    logic [23:0] t, b;
    r = n / (BD * NC);
    p = (n / NC) % BD;
    c = n % NC;
    t = mem[r * NC + c];
    b = mem[(r + NR / 2) * NC + c];
    return {t[16+p], t[8+p], t[p], b[16+p], b[8+p], b[p],
            4'(r), 3'(p), c == NC - 1};
  endfunction

  // Strobe s: even strobes read the top row, odd ones the bottom row.
  function automatic logic [15:0] exp_addr(int s);
    int n;
    n = s / 2;
    return 16'(((n / (BD * NC)) + (s % 2) * (NR / 2)) * NC + n % NC);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    led_frame_reader_if #(.ROW_W(4), .PLANE_W(3)) pix ();
    logic [23:0] pipe [0:1];
    logic        rdy_g;
    int pops = 0, strobes = 0, dones = 0;
    int first_strobe = 0, first_valid = 0, first_pop = 0, last_pop = 0;
    logic seen_v = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [13:0] pd = '0;
    logic [13:0] got [0:NP-1];

    led_frame_reader #(
      .NUM_ROWS    (NR),
      .NUM_COLS    (NC),
      .BIT_DEPTH   (BD),
      .RAM_LATENCY (g + 1)
    ) u_dut (
      .clk_in         (clk),
      .n_reset_in     (rst),
      .enable_in      (enable),
      .ram_en_out     (ram_en[g]),
      .ram_addr_out   (ram_addr[g]),
      .ram_data_in    (ram_data[g]),
      .pix            (pix),
      .frame_done_out (done[g])
    );

    always @(posedge clk) begin
      pipe[0] <= ram_en[g] ? mem[ram_addr[g][10:0]] : 24'h5A5A5A;
      pipe[1] <= pipe[0];
    end

    assign ram_data[g]   = pipe[g];
    assign rdy_g         = (g == 0) ? rdy0 : rdy1;
    assign pix.pix_ready = rdy_g;
    assign vld[g]        = pix.pix_valid;
    assign obs[g]        = {pix.pix_top, pix.pix_bot, pix.pix_row,
                            pix.pix_plane, pix.pix_last};

    always @(negedge clk) begin
      if (rst) begin
        pops    = 0;
        strobes = 0;
        seen_v  = 1'b0;
        pv      = 1'b0;
        pr      = 1'b0;
      end else begin
        if (ram_en[g]) begin
          if (strobes == 0) first_strobe = cyc;
          chk($sformatf("addr%0d_s%0d", g, strobes), ram_addr[g],
              exp_addr(strobes % (2 * NP)));
          strobes++;
        end
        if (vld[g] && !seen_v) begin
          seen_v      = 1'b1;
          first_valid = cyc;
        end
        if (pv && !pr) begin
          chk($sformatf("hold_valid%0d", g), vld[g], 1);
          chk($sformatf("hold_data%0d", g), obs[g], pd);
        end
        if (vld[g] && rdy_g) begin
          if (pops == 0) first_pop = cyc;
          chk($sformatf("pair%0d_n%0d", g, pops), obs[g],
              exp_pair(pops % NP));
          got[pops % NP] = obs[g];
          pops++;
          last_pop = cyc;
        end
        if (done[g]) begin
          dones++;
          chk($sformatf("done_pairs%0d", g), pops, NP);
          chk($sformatf("done_timing%0d", g), last_pop, cyc - 1);
        end
        pv = vld[g];
        pr = rdy_g;
        pd = obs[g];
      end
    end
  end

  initial begin
    rdy1 = 1'b0;
    forever begin
      @(posedge clk);
      #1 rdy1 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int c0;
    logic idle_ok;
    for (int i = 0; i < 2048; i++) mem[i] = 24'h0;
    mem[0 * NC + 5]  = 24'hFF0000;
    mem[16 * NC + 5] = 24'h0000FF;
    mem[3 * NC + 0]  = 24'h800000;

    chk("model_r0p0c5", exp_pair(5), {3'b100, 3'b001, 4'd0, 3'd0, 1'b0});
    chk("model_r0p3c5", exp_pair(3 * 64 + 5),
        {3'b100, 3'b001, 4'd0, 3'd3, 1'b0});
    chk("model_r3p7c0", exp_pair(1984), {3'b100, 3'b000, 4'd3, 3'd7, 1'b0});
    chk("model_r3p6c0", exp_pair(1920), {3'b000, 3'b000, 4'd3, 3'd6, 1'b0});
    chk("model_last", exp_pair(8191), {3'b000, 3'b000, 4'd15, 3'd7, 1'b1});
    chk("model_addr1", exp_addr(1), 16'd1024);
    chk("model_addr3", exp_addr(3), 16'd1025);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", ram_en[0], 0);
    chk("rst_ram_addr", ram_addr[0], 0);
    chk("rst_valid", vld[0], 0);
    chk("rst_tags", obs[0], 0);
    chk("rst_done", done[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    enable = 1'b1;
    c0 = cyc;
    n = 0;
    while (g_dut[0].pops < 100 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pair100", n < TMO, 1);
    enable = 1'b0;
    n = 0;
    while ((g_dut[0].dones < 1 || g_dut[1].dones < 1) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("frame1_done_tmo", n < TMO, 1);

    chk("first_strobe0", g_dut[0].first_strobe, c0 + 1);
    chk("first_strobe1", g_dut[1].first_strobe, c0 + 1);
    chk("first_valid_lat1", g_dut[0].first_valid - g_dut[0].first_strobe, 3);
    chk("first_valid_lat2", g_dut[1].first_valid - g_dut[1].first_strobe, 4);
    chk("rate_lat1", g_dut[0].last_pop - g_dut[0].first_pop, 2 * (NP - 1));
    chk("pairs_lat1", g_dut[0].pops, NP);
    chk("pairs_lat2", g_dut[1].pops, NP);
    chk("strobes_lat1", g_dut[0].strobes, 2 * NP);
    chk("got_r0p0c5", g_dut[0].got[5], {3'b100, 3'b001, 4'd0, 3'd0, 1'b0});
    chk("got_r0p1c5", g_dut[0].got[69], {3'b100, 3'b001, 4'd0, 3'd1, 1'b0});
    chk("got_r0p1c6", g_dut[0].got[70], {3'b000, 3'b000, 4'd0, 3'd1, 1'b0});
    chk("got_r3p7c0", g_dut[0].got[1984], {3'b100, 3'b000, 4'd3, 3'd7, 1'b0});
    chk("got_r3p6c0", g_dut[0].got[1920], {3'b000, 3'b000, 4'd3, 3'd6, 1'b0});
    chk("got_lat2_c5", g_dut[1].got[5], {3'b100, 3'b001, 4'd0, 3'd0, 1'b0});

    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ram_en[0] || ram_en[1] || vld[0] || vld[1]) idle_ok = 1'b0;
    end
    chk("idle_after_frame", idle_ok, 1);
    chk("done_once0", g_dut[0].dones, 1);
    chk("done_once1", g_dut[1].dones, 1);

    enable = 1'b1;
    n = 0;
    while (g_dut[0].pops < 3000 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pair3000", n < TMO, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("mid_rst_en%0d", g), ram_en[g], 0);
      chk($sformatf("mid_rst_addr%0d", g), ram_addr[g], 0);
      chk($sformatf("mid_rst_valid%0d", g), vld[g], 0);
      chk($sformatf("mid_rst_tags%0d", g), obs[g], 0);
      chk($sformatf("mid_rst_done%0d", g), done[g], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while ((g_dut[0].dones < 2 || g_dut[1].dones < 2) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("frame2_done_tmo", n < TMO, 1);
    chk("restart_first", g_dut[0].got[0], {3'b000, 3'b000, 4'd0, 3'd0, 1'b0});
    chk("restart_c5", g_dut[0].got[5], {3'b100, 3'b001, 4'd0, 3'd0, 1'b0});
    chk("frame2_pairs0", g_dut[0].pops, NP);
    chk("frame2_pairs1", g_dut[1].pops, NP);

    idle_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ram_en[0] || ram_en[1]) idle_ok = 1'b0;
    end
    chk("idle_after_frame2", idle_ok, 1);
    chk("done_total0", g_dut[0].dones, 2);
    chk("done_total1", g_dut[1].dones, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
